dct8_stream_core: RTL and testbench

- Parametrised, handshaked successor of the 8-point 1-D DCT-II plus fraction-to-integer stage used in the EEG compression path.
- Accepts one block of eight signed samples per transaction and computes all eight coefficients with eight parallel MAC lanes over eight cycles.
- Rounds and saturates the coefficients to a configurable integer width, then holds them until the downstream RLE stage accepts.

---
 rtl/dct8_stream_core.sv | 155 +++++++++++++++
 tb/tb_dct8_stream_core.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dct8_stream_core.sv
// 8-point 1-D DCT-II with round/saturate to OUT_W and a valid/ready hold stage.
// Optional macro DCT_SAT_FLAG_EN adds out_sat (per-coefficient clip) and sticky sat_seen.
module dct8_stream_core #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 12,
  parameter int COEF_W    = 12,
  parameter int COEF_FRAC = 10,
  parameter int ACC_W     = IN_W + COEF_W + 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_x0,
  input  logic signed [IN_W-1:0]  in_x1,
  input  logic signed [IN_W-1:0]  in_x2,
  input  logic signed [IN_W-1:0]  in_x3,
  input  logic signed [IN_W-1:0]  in_x4,
  input  logic signed [IN_W-1:0]  in_x5,
  input  logic signed [IN_W-1:0]  in_x6,
  input  logic signed [IN_W-1:0]  in_x7,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_z0,
  output logic signed [OUT_W-1:0] out_z1,
  output logic signed [OUT_W-1:0] out_z2,
  output logic signed [OUT_W-1:0] out_z3,
  output logic signed [OUT_W-1:0] out_z4,
  output logic signed [OUT_W-1:0] out_z5,
  output logic signed [OUT_W-1:0] out_z6,
  output logic signed [OUT_W-1:0] out_z7
`ifdef DCT_SAT_FLAG_EN
  ,
  output logic [7:0]              out_sat,
  output logic                    sat_seen
`endif
);

  // Row k holds C[k][0..7], Q.COEF_FRAC, generated for the default widths.
  localparam int ROM [64] = '{
     362,  362,  362,  362,  362,  362,  362,  362,
     502,  426,  284,  100, -100, -284, -426, -502,
     473,  196, -196, -473, -473, -196,  196,  473,
     426, -100, -502, -284,  284,  502,  100, -426,
     362, -362, -362,  362,  362, -362, -362,  362,
     284, -502,  100,  426, -426, -100,  502, -284,
     196, -473,  473, -196, -196,  473, -473,  196,
     100, -284,  426, -502,  502, -426,  284, -100
  };

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] OMAX = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] OMIN = ACC_W'(-(2 ** (OUT_W - 1)));

  typedef enum logic [1:0] {IDLE, CALC, ROUND, HOLD} state_t;

  state_t                  state;
  logic [2:0]              idx;
  logic signed [IN_W-1:0]  x     [8];
  logic signed [ACC_W-1:0] acc   [8];
  logic signed [OUT_W-1:0] z     [8];
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] prod  [8];
  logic signed [ACC_W-1:0] r_full[8];
  logic signed [OUT_W-1:0] z_rnd [8];
  logic [7:0]              clip;

  always_comb begin
    x_ext = ACC_W'(x[idx]);
    clip  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      prod[k]   = x_ext * ACC_W'(COEF_W'(ROM[{k[2:0], idx}]));
      r_full[k] = acc[k] >>> COEF_FRAC;
      if (r_full[k] > OMAX) begin
        z_rnd[k] = OMAX[OUT_W-1:0];
        clip[k]  = 1'b1;
      end else if (r_full[k] < OMIN) begin
        z_rnd[k] = OMIN[OUT_W-1:0];
        clip[k]  = 1'b1;
      end else begin
        z_rnd[k] = r_full[k][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
        x[k]   <= '0;
        acc[k] <= '0;
        z[k]   <= '0;
      end
`ifdef DCT_SAT_FLAG_EN
      out_sat  <= '0;
      sat_seen <= 1'b0;
`endif
    end else if (en) begin
      case (state)
        IDLE: if (in_valid) begin
          x[0] <= in_x0; x[1] <= in_x1; x[2] <= in_x2; x[3] <= in_x3;
          x[4] <= in_x4; x[5] <= in_x5; x[6] <= in_x6; x[7] <= in_x7;
          for (int unsigned k = 0; k < 8; k++) acc[k] <= '0;
          idx      <= '0;
          in_ready <= 1'b0;
          state    <= CALC;
        end
        CALC: begin
          for (int unsigned k = 0; k < 8; k++) acc[k] <= acc[k] + prod[k];
          idx <= idx + 3'd1;
          if (idx == 3'd7) state <= ROUND;
        end
        // ROUND spans two edges, phase in idx[0]: add the half-LSB bias, then shift/clip/register.
        ROUND: if (!idx[0]) begin
          for (int unsigned k = 0; k < 8; k++) acc[k] <= acc[k] + HALF;
          idx <= 3'd1;
        end else begin
          for (int unsigned k = 0; k < 8; k++) z[k] <= z_rnd[k];
          idx       <= '0;
          out_valid <= 1'b1;
          state     <= HOLD;
`ifdef DCT_SAT_FLAG_EN
          out_sat <= clip;
          if (|clip) sat_seen <= 1'b1;
`endif
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef DCT_SAT_FLAG_EN
  logic unused_clip;
  assign unused_clip = ^clip;
`endif

  assign out_z0 = z[0];
  assign out_z1 = z[1];
  assign out_z2 = z[2];
  assign out_z3 = z[3];
  assign out_z4 = z[4];
  assign out_z5 = z[5];
  assign out_z6 = z[6];
  assign out_z7 = z[7];

endmodule

// File: tb/tb_dct8_stream_core.sv
// Bench for dct8_stream_core: a default instance and an OUT_W=8 instance share stimulus,
// both compared every cycle against a transaction-level DCT model.
module tb_dct8_stream_core;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 12;
  localparam int SAT_W  = 8;
  localparam int FRAC   = 10;
  localparam int LAT    = 10;
  localparam int NBLK   = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, in_valid, out_ready;
  logic signed [IN_W-1:0]  x  [8];
  logic                    in_ready, out_valid, s_in_ready, s_out_valid;
  logic signed [OUT_W-1:0] z  [8];
  logic signed [SAT_W-1:0] sz [8];
`ifdef DCT_SAT_FLAG_EN
  logic [7:0] out_sat, s_out_sat;
  logic       sat_seen, s_sat_seen;
`endif

  dct8_stream_core u_dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_x0(x[0]), .in_x1(x[1]), .in_x2(x[2]), .in_x3(x[3]),
    .in_x4(x[4]), .in_x5(x[5]), .in_x6(x[6]), .in_x7(x[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z0(z[0]), .out_z1(z[1]), .out_z2(z[2]), .out_z3(z[3]),
    .out_z4(z[4]), .out_z5(z[5]), .out_z6(z[6]), .out_z7(z[7])
`ifdef DCT_SAT_FLAG_EN
    , .out_sat(out_sat), .sat_seen(sat_seen)
`endif
  );

  dct8_stream_core #(.OUT_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_x0(x[0]), .in_x1(x[1]), .in_x2(x[2]), .in_x3(x[3]),
    .in_x4(x[4]), .in_x5(x[5]), .in_x6(x[6]), .in_x7(x[7]),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_z0(sz[0]), .out_z1(sz[1]), .out_z2(sz[2]), .out_z3(sz[3]),
    .out_z4(sz[4]), .out_z5(sz[5]), .out_z6(sz[6]), .out_z7(sz[7])
`ifdef DCT_SAT_FLAG_EN
    , .out_sat(s_out_sat), .sat_seen(s_sat_seen)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int blocks_done = 0;
  int cyc = 0;

  longint coef [8][8];

  // Transaction-level model: ready/valid flags, countdown to result, last presented result.
  bit     m_ready, m_valid;
  int     m_cnt;
  longint m_z [8], m_sz [8], e_z [8], e_sz [8];
  logic [7:0] m_clip, m_sclip, e_clip, e_sclip;
  bit     m_seen, m_sseen;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic longint clamp(input longint v, input int w, output bit clipped);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    clipped = (v > hi) || (v < lo);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic compute_block();
    longint acc, r;
    bit c;
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int n = 0; n < 8; n++) acc += longint'(x[n]) * coef[k][n];
      r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
      e_z[k]  = clamp(r, OUT_W, c); e_clip[k]  = c;
      e_sz[k] = clamp(r, SAT_W, c); e_sclip[k] = c;
    end
  endtask

  task automatic model_reset();
    m_ready = 1; m_valid = 0; m_cnt = 0;
    m_clip = '0; m_sclip = '0; m_seen = 0; m_sseen = 0;
    for (int k = 0; k < 8; k++) begin m_z[k] = 0; m_sz[k] = 0; end
  endtask

  task automatic model_edge();
    if (rst) model_reset();
    else if (en) begin
      if (m_valid) begin
        if (out_ready) begin m_valid = 0; m_ready = 1; blocks_done++; end
      end else if (!m_ready) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1;
          m_z = e_z; m_sz = e_sz; m_clip = e_clip; m_sclip = e_sclip;
          if (|e_clip)  m_seen  = 1;
          if (|e_sclip) m_sseen = 1;
        end
      end else if (in_valid) begin
        compute_block();
        m_ready = 0; m_cnt = LAT;
      end
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, m_valid);
    chk("s_in_ready", s_in_ready, m_ready);
    chk("s_out_valid", s_out_valid, m_valid);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("z%0d", k), z[k], m_z[k]);
      chk($sformatf("sz%0d", k), sz[k], m_sz[k]);
    end
`ifdef DCT_SAT_FLAG_EN
    chk("out_sat", out_sat, m_clip);
    chk("sat_seen", sat_seen, m_seen);
    chk("s_out_sat", s_out_sat, m_sclip);
    chk("s_sat_seen", s_sat_seen, m_sseen);
`endif
  endtask

  task automatic step(input bit r, input bit e, input bit iv, input bit ordy);
    rst = r; en = e; in_valid = iv; out_ready = ordy;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic set_all(input int v);
    for (int n = 0; n < 8; n++) x[n] = IN_W'(v);
  endtask

  // Accept a block of constant v, then wait for out_valid; stall drops en for 5 edges mid-CALC.
  task automatic run_block(input int v, input bit stall, output int lat);
    bit e;
    set_all(v);
    step(0, 1, 1, 0);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      e = !(stall && i > 3 && i <= 8);
      step(0, e, 0, 0);
      if (out_valid) begin lat = i; break; end
    end
  endtask

  task automatic drain();
    step(0, 1, 0, 1);
    chk("ready_after_drain", in_ready, 1);
  endtask

  initial begin
    int lat, base;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++)
        coef[k][n] = longint'(int'(1024.0 * ((k == 0) ? 1.0 / $sqrt(2.0) : 1.0) / 2.0
                                   * $cos((2.0 * n + 1.0) * k * 3.14159265358979 / 16.0)));
    rst = 1; en = 0; in_valid = 0; out_ready = 0;
    set_all(0);
    model_reset();

    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z0", z[0], 0);

    run_block(10, 0, lat);
    chk("dc10_latency", lat, 10);
    chk("dc10_z0", z[0], 28);
    for (int k = 1; k < 8; k++) chk($sformatf("dc10_z%0d", k), z[k], 0);
    drain();

    run_block(127, 0, lat);
    chk("max_z0", z[0], 359);
    chk("sat_z0", sz[0], 127);
`ifdef DCT_SAT_FLAG_EN
    chk("sat_flags", s_out_sat, 8'h01);
    chk("sat_sticky", s_sat_seen, 1);
`endif
    drain();

    run_block(-128, 0, lat);
    chk("min_z0", z[0], -362);
    chk("min_z1", z[1], 0);
    chk("sat_min_z0", sz[0], -128);
    drain();

    // Backpressure with a competing block offered while busy.
    run_block(10, 0, lat);
    set_all(50);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0);
    chk("bp_z0", z[0], 28);
    chk("bp_in_ready", in_ready, 0);
    step(0, 1, 0, 1);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);

    run_block(10, 1, lat);
    chk("stall_latency", lat, 15);
    chk("stall_z0", z[0], 28);
    drain();

    // Reset in the middle of CALC discards the block.
    set_all(77);
    step(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 1);
    chk("midrst_no_valid", out_valid, 0);

    base = blocks_done;
    for (int i = 0; i < 60000 && (blocks_done - base) < NBLK; i++) begin
      for (int n = 0; n < 8; n++) x[n] = IN_W'($urandom);
      step(0, $urandom_range(0, 99) < 85, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    chk("random_blocks", blocks_done - base, NBLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
